picomips_ctrl: RTL

- Multi-cycle control unit for the picoMIPS datapath. It fetches an instruction word, decodes it into an ALU function code and datapath selects, and consumes the ALU flags (V,N,Z,C) to resolve branches.
- It is the producer of the `func` codes and the consumer of the `flags` that the ALU emits.
- It sits between the program ROM, the register file/ALU, and the switch/LED I/O.

---
 rtl/alu_codes_pkg.sv | 9 +
 rtl/picomips_pkg.sv | 55 +++++
 rtl/picomips_decode.sv | 30 +++
 rtl/picomips_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/alu_codes_pkg.sv
// ALU function codes shared by the picoMIPS ALU and its control unit.
package alu_codes_pkg;
    localparam logic [2:0] RA       = 3'd0;
    localparam logic [2:0] RB       = 3'd1;
    localparam logic [2:0] RADD     = 3'd2;
    localparam logic [2:0] RSUB     = 3'd3;
    localparam logic [2:0] MULL_INT = 3'd4;
    localparam logic [2:0] MULL_FLT = 3'd5;
endpackage

// File: rtl/picomips_pkg.sv
// Opcodes, FSM states, instruction field positions and the decoded control word
// for the picoMIPS control unit.
package picomips_pkg;
    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_ADDI  = 4'h3,
        OP_SUBI  = 4'h4,
        OP_MULF  = 4'h5,
        OP_MULI  = 4'h6,
        OP_MOVI  = 4'h7,
        OP_BEQ   = 4'h8,
        OP_BNE   = 4'h9,
        OP_JMP   = 4'ha,
        OP_IN    = 4'hb,
        OP_OUT   = 4'hc,
        OP_ILL_D = 4'hd,
        OP_ILL_E = 4'he,
        OP_HALT  = 4'hf
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        WAIT_IN,
        WB,
        HALT
    } state_t;

    localparam int OP_HI  = 17;
    localparam int OP_LO  = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 11;
    localparam int RS_HI  = 10;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // bit position of Z inside {V,N,Z,C}
    localparam int FLAG_Z = 1;

    typedef struct packed {
        logic [2:0] func;
        logic       b_imm_sel;
        logic       writes_rf;
        logic       is_branch;
        logic       branch_on_z;
        logic       is_jmp;
        logic       is_in;
        logic       is_out;
        logic       is_halt;
        logic       illegal;
    } ctrl_t;
endpackage

// File: rtl/picomips_decode.sv
// Combinational opcode decoder: maps an opcode onto the control word.
module picomips_decode
    import picomips_pkg::*;
    import alu_codes_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      cw
);
    always_comb begin
        cw      = '0;
        cw.func = RA;
        case (opcode_t'(opcode))
            OP_NOP:  ;
            OP_ADD:  begin cw.func = RADD;     cw.writes_rf = 1'b1; end
            OP_SUB:  begin cw.func = RSUB;     cw.writes_rf = 1'b1; end
            OP_ADDI: begin cw.func = RADD;     cw.b_imm_sel = 1'b1; cw.writes_rf = 1'b1; end
            OP_SUBI: begin cw.func = RSUB;     cw.b_imm_sel = 1'b1; cw.writes_rf = 1'b1; end
            OP_MULF: begin cw.func = MULL_FLT; cw.b_imm_sel = 1'b1; cw.writes_rf = 1'b1; end
            OP_MULI: begin cw.func = MULL_INT; cw.b_imm_sel = 1'b1; cw.writes_rf = 1'b1; end
            OP_MOVI: begin cw.func = RB;       cw.b_imm_sel = 1'b1; cw.writes_rf = 1'b1; end
            OP_BEQ:  begin cw.func = RSUB;     cw.is_branch = 1'b1; cw.branch_on_z = 1'b1; end
            OP_BNE:  begin cw.func = RSUB;     cw.is_branch = 1'b1; end
            OP_JMP:  cw.is_jmp  = 1'b1;
            OP_IN:   cw.is_in   = 1'b1;
            OP_OUT:  cw.is_out  = 1'b1;
            OP_HALT: cw.is_halt = 1'b1;
            default: cw.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/picomips_ctrl.sv
// picoMIPS multi-cycle control unit: fetch/decode FSM, program counter and
// registered ALU flags for branch resolution.
//
// state   | meaning
// FETCH   | latch ROM word at pc into IR
// EXEC    | drive ALU controls, capture flags, OUT pulses out_we
// WAIT_IN | in_ready high until the switch value is strobed in
// WB      | register-file write, pc update
// HALT    | stopped, left only through reset
module picomips_ctrl
    import picomips_pkg::*;
    import alu_codes_pkg::*;
#(
    parameter int N   = 8,
    parameter int PCW = 6,
    parameter int IW  = 18
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [IW-1:0]  instr,
    input  logic [3:0]     alu_flags,
    input  logic           in_valid,
    output logic [PCW-1:0] pc,
    output logic [2:0]     alu_func,
    output logic           b_imm_sel,
    output logic [N-1:0]   imm,
    output logic [2:0]     rd_addr,
    output logic [2:0]     rs_addr,
    output logic           rf_we,
    output logic           in_sel,
    output logic           in_ready,
    output logic           out_we,
    output logic           halted,
    output logic           illegal
);
    state_t         state, state_nxt;
    logic [IW-1:0]  ir;
    logic [3:0]     flags_q;
    logic [PCW-1:0] pc_nxt;
    logic           load_ir, load_flags, taken;
    logic           unused_flag_bits;
    ctrl_t          cw;

    picomips_decode u_decode (
        .opcode (ir[OP_HI:OP_LO]),
        .cw     (cw)
    );

    assign imm     = ir[IMM_HI:IMM_LO];
    assign rd_addr = ir[RD_HI:RD_LO];
    assign rs_addr = ir[RS_HI:RS_LO];

    // only Z steers branches; V, N and C are kept for completeness of the flag register
    assign unused_flag_bits = ^{flags_q[3:2], flags_q[0]};
    assign taken = cw.is_jmp | (cw.is_branch & (flags_q[FLAG_Z] == cw.branch_on_z));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FETCH;
            pc      <= '0;
            ir      <= '0;
            flags_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (load_ir)    ir      <= instr;
            if (load_flags) flags_q <= alu_flags;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        load_ir    = 1'b0;
        load_flags = 1'b0;
        alu_func   = RA;
        b_imm_sel  = 1'b0;
        rf_we      = 1'b0;
        in_sel     = 1'b0;
        in_ready   = 1'b0;
        out_we     = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                load_ir   = 1'b1;
                state_nxt = (instr[OP_HI:OP_LO] == OP_IN) ? WAIT_IN : EXEC;
            end
            EXEC: begin
                alu_func   = cw.func;
                b_imm_sel  = cw.b_imm_sel;
                out_we     = cw.is_out;
                illegal    = cw.illegal;
                load_flags = 1'b1;
                state_nxt  = WB;
            end
            WAIT_IN: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = WB;
            end
            WB: begin
                alu_func  = cw.func;
                b_imm_sel = cw.b_imm_sel;
                rf_we     = cw.writes_rf | cw.is_in;
                in_sel    = cw.is_in;
                if (cw.is_halt) begin
                    state_nxt = HALT;
                end else begin
                    state_nxt = FETCH;
                    pc_nxt    = taken ? ir[IMM_LO +: PCW] : pc + PCW'(1);
                end
            end
            HALT: halted = 1'b1;
            default: state_nxt = FETCH;
        endcase
    end
endmodule
